// File: rtl/johnson_seq_ctrl.sv
// Run/stop/step sequencer for a 4-bit Johnson counter: prescaled advance strobes, illegal-state recovery, cycle count.
// Every output is registered one edge after the deciding inputs; requests are single-cycle pulses with no backpressure.
module johnson_seq_ctrl #(
    parameter int TICK_DIV = 25_000_000,
    parameter int CYCLE_W  = 16
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    input  logic               dir,
    input  logic [3:0]         q,
    output logic               cnt_en,
    output logic               cnt_dir,
    output logic               cnt_clr,
    output logic               busy,
    output logic               fault,
    output logic [CYCLE_W-1:0] cycles
);

    localparam int            PW     = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] P_TICK = PW'(TICK_DIV - 2);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FAULT = 2'd2} state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [3:0]    r_q_prev;
    logic          r_clr_d;
    logic          w_legal, w_illegal, w_start_acc, w_step_acc, w_tick;
    logic          w_en_nxt, w_dir_nxt, w_clr_nxt, w_busy_nxt, w_fault_nxt, w_cycle_done;

    always_comb begin
        case (q)
            4'b0000, 4'b0001, 4'b0011, 4'b0111,
            4'b1111, 4'b1110, 4'b1100, 4'b1000: w_legal = 1'b1;
            default:                            w_legal = 1'b0;
        endcase
    end

    // While the clear strobe is out the counter has not loaded yet, so q is not judged.
    assign w_illegal = !w_legal && !cnt_clr;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_illegal) begin
            w_state_nxt = S_FAULT;
        end else begin
            case (r_state)
                S_IDLE:  if (start && !stop) w_state_nxt = S_RUN;
                S_RUN:   if (stop) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_start_acc  = (r_state == S_IDLE) && !w_illegal && start && !stop;
        w_step_acc   = (r_state == S_IDLE) && !w_illegal && step && !start && !stop;
        // Strobe is registered, so it is decided one count before the wrap to land on it.
        w_tick       = (r_state == S_RUN) && !w_illegal && !stop && (r_presc == P_TICK);
        w_en_nxt     = w_step_acc || w_tick;
        w_dir_nxt    = w_en_nxt ? dir : cnt_dir;
        w_clr_nxt    = (w_state_nxt == S_FAULT);
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_fault_nxt  = fault;
        if (w_clr_nxt) begin
            w_fault_nxt = 1'b1;
        end else if (w_start_acc) begin
            w_fault_nxt = 1'b0;
        end
        w_presc_nxt = '0;
        if ((r_state == S_RUN) && (r_presc != P_LAST)) begin
            w_presc_nxt = r_presc + 1'b1;
        end
        w_cycle_done = (q == 4'b0000) && (r_q_prev != 4'b0000) && !r_clr_d;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_en   <= 1'b0;
            cnt_dir  <= 1'b0;
            cnt_clr  <= 1'b0;
            busy     <= 1'b0;
            fault    <= 1'b0;
            cycles   <= '0;
            r_presc  <= '0;
            r_q_prev <= 4'b0000;
            r_clr_d  <= 1'b0;
        end else begin
            cnt_en   <= w_en_nxt;
            cnt_dir  <= w_dir_nxt;
            cnt_clr  <= w_clr_nxt;
            busy     <= w_busy_nxt;
            fault    <= w_fault_nxt;
            r_presc  <= w_presc_nxt;
            r_q_prev <= q;
            r_clr_d  <= cnt_clr;
            if (w_cycle_done) begin
                cycles <= cycles + 1'b1;
            end
        end
    end

endmodule
